// File: rtl/bop_pkg.sv
// Shared types and defaults for the buffer-overflow protection controller.
package bop_pkg;

  typedef enum logic [2:0] {
    DISABLED,
    ARMING,
    ARMED,
    REPORT,
    CLEAR
  } bop_ctrl_state_e;

  localparam int BOP_ARM_DELAY    = 4;
  localparam int BOP_CLEAR_CYCLES = 8;
  localparam int BOP_CNT_W        = 16;
  localparam int BOP_CNT_MAX_W    = 32;

  // cnt is stored at full width; the controller exposes only its low CNT_W bits
  typedef struct packed {
    logic [31:0]              pc;
    logic [BOP_CNT_MAX_W-1:0] cnt;
  } bop_crash_t;

  function automatic int bop_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bop_timer.sv
// Loadable down-counter with a zero flag, shared by the arming and clearing phases.
module bop_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/bop_crash_ctrl.sv
// Sequencer for the BOP datapath: arms bop_unit, filters its crash flag, reports
// each attack through valid/ready and then clears the circular buffer.
module bop_crash_ctrl
  import bop_pkg::*;
#(
  parameter int ARM_DELAY    = BOP_ARM_DELAY,
  parameter int CLEAR_CYCLES = BOP_CLEAR_CYCLES,
  parameter int CNT_W        = BOP_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_en_i,
  input  logic             cfg_clear_i,
  input  logic             flush_i,
  input  logic             to_crash_i,
  input  logic [31:0]      pc_i,
  output logic             en_crash_o,
  output logic             rst_buf_o,
  output logic             crash_valid_o,
  input  logic             crash_ready_i,
  output logic [31:0]      crash_pc_o,
  output logic [CNT_W-1:0] crash_cnt_o,
  output logic             busy_o
);

  localparam int TW = $clog2(bop_max(ARM_DELAY, CLEAR_CYCLES) + 1);
  // Timer is loaded with N-1 so that the zero flag marks the N-th cycle in the state
  localparam logic [TW-1:0] ARM_LOAD   = TW'((ARM_DELAY > 0) ? ARM_DELAY - 1 : 0);
  localparam logic [TW-1:0] CLEAR_LOAD = TW'(CLEAR_CYCLES - 1);
  localparam logic [BOP_CNT_MAX_W-1:0] CNT_MAX =
    {BOP_CNT_MAX_W{1'b1}} >> (BOP_CNT_MAX_W - CNT_W);

  bop_ctrl_state_e state_q;
  bop_crash_t      crash_q;
  logic            crash_ok;
  logic            timer_load;
  logic            timer_zero;
  logic [TW-1:0]   timer_val;

  assign crash_ok = to_crash_i & ~flush_i;

  always_comb begin
    timer_load = 1'b0;
    timer_val  = CLEAR_LOAD;
    case (state_q)
      DISABLED: begin
        timer_load = cfg_clear_i | (cfg_en_i & (ARM_DELAY > 0));
        if (!cfg_clear_i) timer_val = ARM_LOAD;
      end
      ARMED:   timer_load = ~crash_ok & cfg_clear_i;
      REPORT:  timer_load = crash_ready_i;
      default: timer_load = 1'b0;
    endcase
  end

  bop_timer #(.W(TW)) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DISABLED;
      crash_q <= '0;
    end else begin
      case (state_q)
        DISABLED: begin
          if (cfg_clear_i)   state_q <= CLEAR;
          else if (cfg_en_i) state_q <= (ARM_DELAY == 0) ? ARMED : ARMING;
        end
        ARMING: begin
          if (!cfg_en_i)       state_q <= DISABLED;
          else if (timer_zero) state_q <= ARMED;
        end
        ARMED: begin
          if (crash_ok) begin
            state_q    <= REPORT;
            crash_q.pc <= pc_i;
            if (crash_q.cnt < CNT_MAX) crash_q.cnt <= crash_q.cnt + BOP_CNT_MAX_W'(1);
          end else if (cfg_clear_i) begin
            state_q <= CLEAR;
          end else if (!cfg_en_i) begin
            state_q <= DISABLED;
          end
        end
        REPORT: begin
          if (crash_ready_i) state_q <= CLEAR;
        end
        CLEAR: begin
          if (timer_zero) state_q <= cfg_en_i ? ARMED : DISABLED;
        end
        default: state_q <= DISABLED;
      endcase
    end
  end

  assign en_crash_o    = (state_q == ARMED);
  assign rst_buf_o     = (state_q == CLEAR);
  assign crash_valid_o = (state_q == REPORT);
  assign busy_o        = (state_q == ARMING) || (state_q == REPORT) || (state_q == CLEAR);
  assign crash_pc_o    = crash_q.pc;
  assign crash_cnt_o   = crash_q.cnt[CNT_W-1:0];

endmodule

// File: tb/tb_bop_crash_ctrl.sv
// Directed and randomized checks of bop_crash_ctrl against a cycle-level behavioural model.
module tb_bop_crash_ctrl;

  localparam int AD   = 4;
  localparam int CC   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  localparam int M_OFF = 0, M_ARMING = 1, M_ON = 2, M_REP = 3, M_CLR = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cfg_en_i = 1'b0;
  logic          cfg_clear_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          to_crash_i = 1'b0;
  logic [31:0]   pc_i = '0;
  logic          crash_ready_i = 1'b0;
  logic          en_crash_o;
  logic          rst_buf_o;
  logic          crash_valid_o;
  logic [31:0]   crash_pc_o;
  logic [CW-1:0] crash_cnt_o;
  logic          busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  int          m_mode;
  int          m_left;
  logic [31:0] m_pc;
  int          m_cnt;

  bop_crash_ctrl #(.ARM_DELAY(AD), .CLEAR_CYCLES(CC), .CNT_W(CW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cfg_en_i      (cfg_en_i),
    .cfg_clear_i   (cfg_clear_i),
    .flush_i       (flush_i),
    .to_crash_i    (to_crash_i),
    .pc_i          (pc_i),
    .en_crash_o    (en_crash_o),
    .rst_buf_o     (rst_buf_o),
    .crash_valid_o (crash_valid_o),
    .crash_ready_i (crash_ready_i),
    .crash_pc_o    (crash_pc_o),
    .crash_cnt_o   (crash_cnt_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF;
    m_left = 0;
    m_pc   = '0;
    m_cnt  = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs held across that edge
  task automatic model_step();
    if (!rst_ni) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_OFF: begin
        if (cfg_clear_i) begin
          m_mode = M_CLR; m_left = CC;
        end else if (cfg_en_i) begin
          if (AD == 0) m_mode = M_ON;
          else begin m_mode = M_ARMING; m_left = AD; end
        end
      end
      M_ARMING: begin
        if (!cfg_en_i) m_mode = M_OFF;
        else begin
          m_left--;
          if (m_left == 0) m_mode = M_ON;
        end
      end
      M_ON: begin
        if (to_crash_i && !flush_i) begin
          m_pc = pc_i;
          if (m_cnt < CMAX) m_cnt++;
          m_mode = M_REP;
        end else if (cfg_clear_i) begin
          m_mode = M_CLR; m_left = CC;
        end else if (!cfg_en_i) begin
          m_mode = M_OFF;
        end
      end
      M_REP: begin
        if (crash_ready_i) begin
          $display("report accepted pc=%08h cnt=%0d", m_pc, m_cnt);
          m_mode = M_CLR; m_left = CC;
        end
      end
      M_CLR: begin
        m_left--;
        if (m_left == 0) m_mode = cfg_en_i ? M_ON : M_OFF;
      end
      default: m_mode = M_OFF;
    endcase
  endtask

  task automatic check_all();
    chk("en_crash", 32'(en_crash_o), 32'(m_mode == M_ON));
    chk("rst_buf", 32'(rst_buf_o), 32'(m_mode == M_CLR));
    chk("crash_valid", 32'(crash_valid_o), 32'(m_mode == M_REP));
    chk("busy", 32'(busy_o), 32'(m_mode == M_ARMING || m_mode == M_REP || m_mode == M_CLR));
    chk("crash_pc", crash_pc_o, m_pc);
    chk("crash_cnt", 32'(crash_cnt_o), 32'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int n;
    logic seen;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    rst_ni = 1'b1;

    // Arm: en_crash from cycle 5, busy in cycles 1-4
    cfg_en_i = 1'b1;
    tick();
    for (int c = 1; c <= 5; c++) begin
      chk("arm_en", 32'(en_crash_o), 32'(c == 5));
      chk("arm_busy", 32'(busy_o), 32'(c <= 4));
      if (c < 5) tick();
    end

    // Crash report held while not accepted
    to_crash_i = 1'b1; pc_i = 32'h8000_0124;
    tick();
    to_crash_i = 1'b0; pc_i = 32'h0;
    chk("crash_valid_first", 32'(crash_valid_o), 32'd1);
    chk("crash_pc_first", crash_pc_o, 32'h8000_0124);
    chk("crash_cnt_first", 32'(crash_cnt_o), 32'd1);
    repeat (3) tick();
    chk("hold_pc", crash_pc_o, 32'h8000_0124);
    chk("hold_en", 32'(en_crash_o), 32'd0);

    // Handshake -> exactly CC cycles of buffer clear, then re-armed
    crash_ready_i = 1'b1;
    tick();
    crash_ready_i = 1'b0;
    n = 0;
    while (rst_buf_o === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("clear_len", 32'(n), 32'(CC));
    chk("rearm_en", 32'(en_crash_o), 32'd1);

    // Second crash, cfg_en dropped during clear -> disabled afterwards
    to_crash_i = 1'b1; pc_i = 32'h0000_4440;
    tick();
    to_crash_i = 1'b0;
    crash_ready_i = 1'b1;
    tick();
    crash_ready_i = 1'b0;
    cfg_en_i = 1'b0;
    repeat (8) tick();
    chk("clear_off_en", 32'(en_crash_o), 32'd0);
    chk("clear_off_busy", 32'(busy_o), 32'd0);

    // Re-arm, then flushed crash must be discarded
    cfg_en_i = 1'b1;
    repeat (5) tick();
    chk("rearm2_en", 32'(en_crash_o), 32'd1);
    to_crash_i = 1'b1; flush_i = 1'b1; pc_i = 32'hdead_beef;
    tick();
    to_crash_i = 1'b0; flush_i = 1'b0;
    chk("flush_valid", 32'(crash_valid_o), 32'd0);
    chk("flush_cnt", 32'(crash_cnt_o), 32'd2);

    // Crash wins over clear and disable in the same cycle
    to_crash_i = 1'b1; cfg_clear_i = 1'b1; cfg_en_i = 1'b0; pc_i = 32'h0000_0abc;
    tick();
    to_crash_i = 1'b0;
    chk("prio_valid", 32'(crash_valid_o), 32'd1);
    chk("prio_cnt", 32'(crash_cnt_o), 32'd3);
    tick();
    cfg_clear_i = 1'b0;
    crash_ready_i = 1'b1;
    tick();
    crash_ready_i = 1'b0;
    repeat (8) tick();
    chk("prio_off", 32'(busy_o), 32'd0);

    // Abort during arming: en_crash never rises
    seen = 1'b0;
    cfg_en_i = 1'b1;
    repeat (3) begin tick(); seen |= en_crash_o; end
    cfg_en_i = 1'b0;
    repeat (10) begin tick(); seen |= en_crash_o; end
    chk("abort_never_en", 32'(seen), 32'd0);

    // Fourth crash saturates the 2-bit counter
    cfg_en_i = 1'b1;
    repeat (5) tick();
    to_crash_i = 1'b1; pc_i = 32'h1234_5678;
    tick();
    to_crash_i = 1'b0;
    chk("sat_cnt", 32'(crash_cnt_o), 32'd3);
    crash_ready_i = 1'b1;
    tick();
    crash_ready_i = 1'b0;
    repeat (2) tick();

    // Asynchronous reset in the middle of the clear
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("async_rst_buf", 32'(rst_buf_o), 32'd0);
    check_all();
    tick();
    rst_ni = 1'b1;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cfg_en_i      = ($urandom_range(0, 15) != 0);
      cfg_clear_i   = ($urandom_range(0, 15) == 0);
      flush_i       = ($urandom_range(0, 3) == 0);
      to_crash_i    = ($urandom_range(0, 5) == 0);
      crash_ready_i = ($urandom_range(0, 2) == 0);
      pc_i          = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
